// File: rtl/note_pkg.sv
// note_pkg: shared constants, note indices and FSM state for the note mixer.
package note_pkg;
  localparam int NUM_NOTES = 36;
  localparam int AMP_W = 16;
  localparam int ACC_W = 22;
  localparam int IDX_W = 6;
  localparam int IDX_C1 = 0, IDX_CS1 = 1, IDX_D1 = 2, IDX_DS1 = 3, IDX_E1 = 4, IDX_F1 = 5,
                 IDX_FS1 = 6, IDX_G1 = 7, IDX_GS1 = 8, IDX_A1 = 9, IDX_AS1 = 10, IDX_B1 = 11;
  localparam int IDX_C2 = 12, IDX_CS2 = 13, IDX_D2 = 14, IDX_DS2 = 15, IDX_E2 = 16, IDX_F2 = 17,
                 IDX_FS2 = 18, IDX_G2 = 19, IDX_GS2 = 20, IDX_A2 = 21, IDX_AS2 = 22, IDX_B2 = 23;
  localparam int IDX_C3 = 24, IDX_CS3 = 25, IDX_D3 = 26, IDX_DS3 = 27, IDX_E3 = 28, IDX_F3 = 29,
                 IDX_FS3 = 30, IDX_G3 = 31, IDX_GS3 = 32, IDX_A3 = 33, IDX_AS3 = 34, IDX_B3 = 35;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic logic [5:0] popcount(input logic [NUM_NOTES-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < NUM_NOTES; i++) c += 6'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/key_sync.sv
// key_sync: per-bit two-flop synchroniser with synchronous active-low reset.
module key_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/note_mixer.sv
// note_mixer: time-multiplexed sum of the pressed note waveforms into one saturated sample per request.
module note_mixer #(
  parameter int NUM_NOTES = note_pkg::NUM_NOTES,
  parameter int AMP_W = note_pkg::AMP_W,
  parameter int SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_NOTES*AMP_W-1:0] notes_in,
  input  logic [NUM_NOTES-1:0]       keys,
  input  logic                       sample_req,
  output logic [AMP_W-1:0]           sample_out,
  output logic                       sample_valid,
  output logic [5:0]                 active_count,
  output logic                       busy,
  output logic                       overrun
);
  import note_pkg::*;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NOTES - 1);
  state_t state_q, state_d;
  logic [NUM_NOTES-1:0] keys_s, snap_q, snap_d;
  logic [ACC_W-1:0] acc_q, acc_d, shifted;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AMP_W-1:0] sample_q, sample_d, note_cur, sat;
  logic [5:0] count_q, count_d;
  logic valid_q, valid_d, overrun_q, overrun_d, start, accum, done;
  key_sync #(.W(NUM_NOTES)) u_sync (.clk(clk), .rst(rst), .d(keys), .q(keys_s));
  assign start = state_q == IDLE && sample_req;
  assign accum = state_q == ACCUM;
  assign done = state_q == DONE;
  assign note_cur = notes_in[int'(idx_q)*AMP_W +: AMP_W];
  assign shifted = acc_q >> SHIFT;
  assign sat = |shifted[ACC_W-1:AMP_W] ? '1 : shifted[AMP_W-1:0];
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sample_req) state_d = ACCUM;
      ACCUM:   if (idx_q == LAST) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    snap_d = start ? keys_s : snap_q;
    acc_d = start ? '0 : (accum && snap_q[idx_q]) ? acc_q + ACC_W'(note_cur) : acc_q;
    idx_d = start ? '0 : (accum && idx_q != LAST) ? idx_q + 1'b1 : idx_q;
  end
  always_comb begin
    sample_d = done ? sat : sample_q;
    count_d = done ? popcount(snap_q) : count_q;
    valid_d = done;
    overrun_d = overrun_q | (sample_req && state_q != IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      snap_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      sample_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      sample_q <= sample_d;
      count_q <= count_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign sample_out = sample_q;
  assign sample_valid = valid_q;
  assign active_count = count_q;
  assign busy = state_q != IDLE;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_note_mixer.sv
// tb_note_mixer: table-driven checks of note_mixer (SHIFT=0 and SHIFT=1) plus overrun and reset sequences.
module tb_note_mixer;
  import note_pkg::*;
  logic clk = 1'b0, rst = 1'b0, sample_req = 1'b0;
  logic [NUM_NOTES*AMP_W-1:0] notes_in = '0;
  logic [NUM_NOTES-1:0] keys = '0;
  logic [AMP_W-1:0] so0, so1;
  logic sv0, sv1, b0, b1, ov0, ov1;
  logic [5:0] ac0, ac1;
  int tests = 0, fails = 0;
  typedef struct {
    logic [35:0] k;
    logic [15:0] val;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [5:0]  cnt;
  } vec_t;
  vec_t vt[6];
  always #5 clk = ~clk;
  note_mixer #(.SHIFT(0)) dut0 (.clk(clk), .rst(rst), .notes_in(notes_in), .keys(keys),
    .sample_req(sample_req), .sample_out(so0), .sample_valid(sv0), .active_count(ac0),
    .busy(b0), .overrun(ov0));
  note_mixer #(.SHIFT(1)) dut1 (.clk(clk), .rst(rst), .notes_in(notes_in), .keys(keys),
    .sample_req(sample_req), .sample_out(so1), .sample_valid(sv1), .active_count(ac1),
    .busy(b1), .overrun(ov1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic load(input vec_t v);
    for (int i = 0; i < NUM_NOTES; i++)
      notes_in[i*AMP_W +: AMP_W] = v.k[i] ? v.val : 16'($urandom);
    keys = v.k;
    repeat (3) @(negedge clk);
  endtask
  // Returns edges from the accepting edge to the one that raises sample_valid (-1 on timeout).
  task automatic request(output int lat);
    @(negedge clk) sample_req = 1'b1;
    @(negedge clk) sample_req = 1'b0;
    lat = 0;
    while (!sv0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!sv0) lat = -1;
  endtask
  initial begin
    int lat, nv, first;
    vt[0] = '{36'h000000001, 16'h07FF, 16'h07FF, 16'h03FF, 6'd1};
    vt[1] = '{36'h000000091, 16'h01FF, 16'h05FD, 16'h02FE, 6'd3};
    vt[2] = '{36'hFFFFFFFFF, 16'h07FF, 16'hFFFF, 16'h8FEE, 6'd36};
    vt[3] = '{36'h000000000, 16'h1234, 16'h0000, 16'h0000, 6'd0};
    vt[4] = '{36'h800000000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 6'd1};
    vt[5] = '{36'hFFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'd36};
    keys = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) sample_req = ~sample_req;
      chk("rst_out", 32'(so0), 0);
      chk("rst_valid", 32'(sv0), 0);
      chk("rst_busy", 32'(b0), 0);
      chk("rst_overrun", 32'(ov0), 0);
      chk("rst_count", 32'(ac0), 0);
    end
    sample_req = 1'b0;
    keys = '0;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load(vt[i]);
      request(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 37);
      chk($sformatf("v%0d_out", i), 32'(so0), 32'(vt[i].exp0));
      chk($sformatf("v%0d_out_shift1", i), 32'(so1), 32'(vt[i].exp1));
      chk($sformatf("v%0d_count", i), 32'(ac0), 32'(vt[i].cnt));
      chk($sformatf("v%0d_busy", i), 32'(b0), 0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), 32'(sv0), 0);
    end
    chk("no_overrun", 32'(ov0), 0);
    load(vt[1]);
    @(negedge clk) sample_req = 1'b1;
    @(negedge clk) sample_req = 1'b0;
    nv = 0;
    first = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      sample_req = n == 10;
      if (sv0) begin
        nv++;
        if (first < 0) first = n;
        chk("ovr_out", 32'(so0), 32'h05FD);
      end
    end
    sample_req = 1'b0;
    chk("ovr_valids", 32'(nv), 1);
    chk("ovr_latency", 32'(first), 37);
    chk("ovr_flag", 32'(ov0), 1);
    request(lat);
    chk("ovr_clean_latency", 32'(lat), 37);
    chk("ovr_clean_out", 32'(so0), 32'h05FD);
    chk("ovr_sticky", 32'(ov0), 1);
    load(vt[2]);
    @(negedge clk) sample_req = 1'b1;
    @(negedge clk) sample_req = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    chk("mid_busy", 32'(b0), 0);
    chk("mid_out", 32'(so0), 0);
    chk("mid_count", 32'(ac0), 0);
    chk("mid_overrun", 32'(ov0), 0);
    nv = 0;
    repeat (50) begin
      @(negedge clk);
      if (sv0) nv++;
    end
    chk("mid_no_valid", 32'(nv), 0);
    chk("mid_out_held", 32'(so0), 0);
    request(lat);
    chk("mid_after_latency", 32'(lat), 37);
    chk("mid_after_out", 32'(so0), 32'hFFFF);
    chk("mid_after_out_shift1", 32'(so1), 32'h8FEE);
    chk("mid_after_count", 32'(ac0), 36);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
